flex_out_ext: RTL

FLEX_OUT_EXT -- requirements
Module: flex_out_ext

---
 rtl/flex_out_ext.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/flex_out_ext.sv
// flex_out_ext: bus-addressable bank of output registers.
// Each register can be written directly, or have bits set, cleared or
// toggled. Any register can be read back. Bits marked in pulse_mask clear
// themselves pulse_len cycles after a write leaves them high. A two-state
// handshake holds dtack until the master drops its request.

`ifndef BB_ADDR_BUS_WIDTH
`define BB_ADDR_BUS_WIDTH 16
`endif
`ifndef BB_DATA_BUS_WIDTH
`define BB_DATA_BUS_WIDTH 16
`endif

module flex_out_ext #(
  parameter int                        addr_bus_width = `BB_ADDR_BUS_WIDTH,
  parameter int                        data_bus_width = `BB_DATA_BUS_WIDTH,
  parameter logic [addr_bus_width-1:0] base_addr      = '0,
  parameter int                        nr_registers   = 4,
  parameter int                        nr_bits        = nr_registers * data_bus_width,
  parameter logic [nr_bits-1:0]        reset_value    = '0,
  parameter logic [nr_bits-1:0]        pulse_mask     = '0,
  parameter int                        pulse_len      = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [addr_bus_width-1:0] addr,
  input  logic [data_bus_width-1:0] data_w,
  input  logic                      addr_strobe,
  input  logic                      read_trg,
  input  logic                      write_trg,
  output logic [data_bus_width-1:0] data_r,
  output logic                      data_r_act,
  output logic                      dtack,
  output logic [nr_bits-1:0]        bits,
  output logic [nr_registers-1:0]   wr_stb
);

  // Register index occupies the low address bits, the write mode the next
  // two bits, and the remaining upper bits select the block itself.
  localparam int RSB = $clog2(nr_registers);
  localparam int IW  = (RSB > 0) ? RSB : 1;
  localparam int TOT = nr_registers * data_bus_width;

  // Reset values and pulse masks widened to the full register storage so
  // that every register slice is defined even if nr_bits is narrower.
  localparam logic [TOT-1:0] RST_EXT = TOT'(reset_value);
  localparam logic [TOT-1:0] MSK_EXT = TOT'(pulse_mask);
  localparam logic [15:0]    PLEN    = 16'(pulse_len);

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_SET    = 2'd1;
  localparam logic [1:0] MODE_CLEAR  = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1
  } state_t;

  // Combine the current register value with the bus data per write mode.
  function automatic logic [data_bus_width-1:0] apply_mode(
    input logic [1:0]                mode_i,
    input logic [data_bus_width-1:0] cur_i,
    input logic [data_bus_width-1:0] dat_i
  );
    logic [data_bus_width-1:0] res;
    case (mode_i)
      MODE_DIRECT: res = dat_i;
      MODE_SET:    res = cur_i | dat_i;
      MODE_CLEAR:  res = cur_i & ~dat_i;
      MODE_TOGGLE: res = cur_i ^ dat_i;
      default:     res = cur_i;
    endcase
    return res;
  endfunction

  logic [IW-1:0]             index;
  logic [1:0]                mode;
  logic                      sel;
  logic                      acc_rd;
  logic                      acc_wr;
  logic                      in_wait;
  logic [nr_registers-1:0]   wr_hit;
  logic [data_bus_width-1:0] rd_val;
  logic [TOT-1:0]            regs_flat;

  state_t                    state_p1;
  state_t                    state_nx;
  logic [data_bus_width-1:0] data_r_p1;
  logic                      rd_act_p1;
  logic [nr_registers-1:0]   wr_stb_p1;

  // Address decode: register index, write mode and block select.
  always_comb begin
    index = '0;
    if (RSB > 0) begin
      index = IW'(addr);
    end
    mode = 2'(addr >> RSB);
    sel  = addr_strobe
           && ((addr >> (RSB + 2)) == (base_addr >> (RSB + 2)))
           && (int'(index) < nr_registers);
  end

  // Read multiplexer over all registers.
  always_comb begin
    rd_val = '0;
    for (int n = 0; n < nr_registers; n++) begin
      if (index == IW'(n)) begin
        rd_val = regs_flat[n*data_bus_width +: data_bus_width];
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p1 <= S_IDLE;
    end else begin
      state_p1 <= state_nx;
    end
  end

  // Next state: an access moves IDLE to WAIT; WAIT holds until the request
  // is withdrawn or the block is deselected. Stray encodings recover to IDLE.
  always_comb begin
    state_nx = S_IDLE;
    case (state_p1)
      S_IDLE:  if (sel && (read_trg || write_trg)) state_nx = S_WAIT;
      S_WAIT:  if (sel && (read_trg || write_trg)) state_nx = S_WAIT;
      default: state_nx = S_IDLE;
    endcase
  end

  // State outputs: accept a read (priority) or a write only in IDLE.
  always_comb begin
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    in_wait = 1'b0;
    case (state_p1)
      S_IDLE: begin
        acc_rd = sel && read_trg;
        acc_wr = sel && write_trg && !read_trg;
      end
      S_WAIT:  in_wait = 1'b1;
      default: ;
    endcase
  end

  // Per-register write-enable derived from the accepted write.
  always_comb begin
    wr_hit = '0;
    for (int n = 0; n < nr_registers; n++) begin
      wr_hit[n] = acc_wr && (index == IW'(n));
    end
  end

  // Read data capture and read-active flag, held for the whole WAIT phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_r_p1 <= '0;
      rd_act_p1 <= 1'b0;
    end else begin
      if (acc_rd) begin
        data_r_p1 <= rd_val;
      end
      rd_act_p1 <= (state_nx == S_WAIT) && (acc_rd || rd_act_p1);
    end
  end

  // Update strobes: one cycle, aligned with the new register value.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_stb_p1 <= '0;
    end else begin
      wr_stb_p1 <= wr_hit;
    end
  end

  for (genvar n = 0; n < nr_registers; n++) begin : g_reg
    localparam logic [data_bus_width-1:0] RV = RST_EXT[n*data_bus_width +: data_bus_width];
    localparam logic [data_bus_width-1:0] PM = MSK_EXT[n*data_bus_width +: data_bus_width];

    logic [data_bus_width-1:0] reg_q;
    logic [data_bus_width-1:0] wr_val;
    logic [15:0]               cnt_q;

    assign wr_val = apply_mode(mode, reg_q, data_w);

    // Register and pulse counter: a write wins over auto-clear and reloads
    // the counter; the clear fires on the counter's 1->0 step so pulse bits
    // stay high for exactly pulse_len cycles.
    always_ff @(posedge clock) begin
      if (reset) begin
        reg_q <= RV;
        cnt_q <= '0;
      end else if (wr_hit[n]) begin
        reg_q <= wr_val;
        cnt_q <= (|(wr_val & PM)) ? PLEN : 16'd0;
      end else if (cnt_q != 16'd0) begin
        cnt_q <= cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          reg_q <= reg_q & ~PM;
        end
      end
    end

    assign regs_flat[n*data_bus_width +: data_bus_width] = reg_q;
  end

  assign data_r     = data_r_p1;
  assign data_r_act = rd_act_p1;
  assign dtack      = in_wait;
  assign wr_stb     = wr_stb_p1;
  assign bits       = nr_bits'(regs_flat);

endmodule
